// File: rtl/laser_pkg.sv
// Shared definitions for the two-circle laser coverage search: FSM states and
// default geometry/frame parameters.
package laser_pkg;
  localparam int CW_DEF         = 4;
  localparam int NPTS_DEF       = 40;
  localparam int R2_DEF         = 16;
  localparam int MAX_ROUNDS_DEF = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SCAN1  = 3'd2,
    SCAN2  = 3'd3,
    CHECK  = 3'd4,
    FINISH = 3'd5
  } state_t;
endpackage

// File: rtl/laser_incircle.sv
// Combinational point-in-circle test: covered when dx^2 + dy^2 <= R2.
module laser_incircle
  import laser_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int R2 = R2_DEF
) (
  input  logic [CW-1:0] px,
  input  logic [CW-1:0] py,
  input  logic [CW-1:0] cx,
  input  logic [CW-1:0] cy,
  output logic          hit
);
  localparam int SW = 2*CW + 3;

  logic signed [CW:0]   dx, dy;
  logic signed [SW-1:0] dxe, dye, d2;

  assign dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
  assign dy  = $signed({1'b0, py}) - $signed({1'b0, cy});
  assign dxe = SW'(dx);
  assign dye = SW'(dy);
  assign d2  = dxe*dxe + dye*dye;
  assign hit = (int'(d2) <= R2);
endmodule

// File: rtl/laser_search.sv
// Two-circle coverage search: loads a frame of points, then alternately
// refines each circle by exhaustive raster scan until the union stops growing.
module laser_search
  import laser_pkg::*;
#(
  parameter int CW         = CW_DEF,
  parameter int NPTS       = NPTS_DEF,
  parameter int R2         = R2_DEF,
  parameter int MAX_ROUNDS = MAX_ROUNDS_DEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  input  logic [CW-1:0]              X,
  input  logic [CW-1:0]              Y,
  output logic [CW-1:0]              C1X,
  output logic [CW-1:0]              C1Y,
  output logic [CW-1:0]              C2X,
  output logic [CW-1:0]              C2Y,
  output logic [$clog2(NPTS+1)-1:0]  COVER,
  output logic                       DONE
);
  localparam int SC = $clog2(NPTS+1);
  localparam int PW = (NPTS > 1) ? $clog2(NPTS) : 1;
  localparam int RW = $clog2(MAX_ROUNDS+1);
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [PW-1:0] PLAST = PW'(NPTS-1);

  state_t          state;
  logic [2*CW-1:0] mem [NPTS];
  logic [PW-1:0]   pidx;
  logic [CW-1:0]   px, py, cx, cy, fx, fy;
  logic [CW-1:0]   bx, by, nbx, nby;
  logic [CW-1:0]   w1x, w1y, w2x, w2y;
  logic [SC-1:0]   acc, best, sc2, base, score, nb;
  logic [RW-1:0]   rnd;
  logic            hit_c, hit_f, better, last_pt, last_cand, load_en;

  assign {px, py} = mem[pidx];
  // The circle not being scanned stays fixed: C2 during SCAN1, C1 during SCAN2.
  assign fx = (state == SCAN2) ? w1x : w2x;
  assign fy = (state == SCAN2) ? w1y : w2y;

  laser_incircle #(.CW(CW), .R2(R2)) u_cand (
    .px(px), .py(py), .cx(cx), .cy(cy), .hit(hit_c)
  );
  laser_incircle #(.CW(CW), .R2(R2)) u_fixed (
    .px(px), .py(py), .cx(fx), .cy(fy), .hit(hit_f)
  );

  assign score     = acc + SC'(hit_c | hit_f);
  assign last_pt   = (pidx == PLAST);
  assign last_cand = (cx == CMAX) && (cy == CMAX);
  assign better    = (score > best);
  assign nb        = better ? score : best;
  assign nbx       = better ? cx : bx;
  assign nby       = better ? cy : by;
  assign load_en   = IN_VALID && ((state == IDLE) || (state == LOAD));

  always_ff @(posedge CLK)
    if (load_en && !RST) mem[pidx] <= {X, Y};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pidx  <= '0;
      rnd   <= '0;
      acc   <= '0;
      best  <= '0;
      sc2   <= '0;
      base  <= '0;
      bx    <= '0;
      by    <= '0;
      cx    <= '0;
      cy    <= '0;
      w1x   <= '0;
      w1y   <= '0;
      w2x   <= '0;
      w2y   <= '0;
      C1X   <= '0;
      C1Y   <= '0;
      C2X   <= '0;
      C2Y   <= '0;
      COVER <= '0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (state == IDLE) begin
            w1x  <= '0;
            w1y  <= '0;
            w2x  <= CMAX;
            w2y  <= CMAX;
            base <= '0;
            rnd  <= '0;
            acc  <= '0;
            best <= '0;
            bx   <= '0;
            by   <= '0;
            cx   <= '0;
            cy   <= '0;
          end
          if (IN_VALID) begin
            if (last_pt) begin
              pidx  <= '0;
              state <= SCAN1;
            end else begin
              pidx  <= pidx + PW'(1);
              state <= LOAD;
            end
          end
        end
        SCAN1, SCAN2: begin
          if (last_pt) begin
            pidx <= '0;
            acc  <= '0;
            if (cx == CMAX) begin
              cx <= '0;
              cy <= cy + CW'(1);
            end else begin
              cx <= cx + CW'(1);
            end
            if (last_cand) begin
              // Clear the best tracker so the next scan starts from score 0.
              best <= '0;
              bx   <= '0;
              by   <= '0;
              if (state == SCAN1) begin
                w1x   <= nbx;
                w1y   <= nby;
                state <= SCAN2;
              end else begin
                w2x   <= nbx;
                w2y   <= nby;
                sc2   <= nb;
                state <= CHECK;
              end
            end else begin
              best <= nb;
              bx   <= nbx;
              by   <= nby;
            end
          end else begin
            pidx <= pidx + PW'(1);
            acc  <= score;
          end
        end
        CHECK: begin
          if ((sc2 > base) && (int'(rnd) + 1 < MAX_ROUNDS)) begin
            base  <= sc2;
            rnd   <= rnd + RW'(1);
            state <= SCAN1;
          end else begin
            C1X   <= w1x;
            C1Y   <= w1y;
            C2X   <= w2x;
            C2Y   <= w2y;
            COVER <= sc2;
            DONE  <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_laser_search.sv
// Bench for laser_search: three default-size instances run the fixed frames in
// parallel, a small instance runs randomized frames against a reference model.
module tb_laser_search;
  localparam int SCW   = 2;
  localparam int SN    = 6;
  localparam int SR2   = 2;
  localparam int SMR   = 3;
  localparam int SSCAN = SN * (1 << (2*SCW));
  localparam int DSCAN = 40 * 256;
  localparam int DCYC  = 4*DSCAN + 2 + 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic       rst_d [3];
  logic       iv_d  [3];
  logic [3:0] x_d   [3];
  logic [3:0] y_d   [3];
  logic [3:0] c1x_d [3];
  logic [3:0] c1y_d [3];
  logic [3:0] c2x_d [3];
  logic [3:0] c2y_d [3];
  logic [5:0] cov_d [3];
  logic       done_d[3];

  for (genvar g = 0; g < 3; g++) begin : g_def
    laser_search u_dut (
      .CLK(CLK), .RST(rst_d[g]), .IN_VALID(iv_d[g]), .X(x_d[g]), .Y(y_d[g]),
      .C1X(c1x_d[g]), .C1Y(c1y_d[g]), .C2X(c2x_d[g]), .C2Y(c2y_d[g]),
      .COVER(cov_d[g]), .DONE(done_d[g])
    );
  end

  logic       rst_s, iv_s, done_s;
  logic [1:0] x_s, y_s, c1x_s, c1y_s, c2x_s, c2y_s;
  logic [2:0] cov_s;

  laser_search #(.CW(SCW), .NPTS(SN), .R2(SR2), .MAX_ROUNDS(SMR)) u_small (
    .CLK(CLK), .RST(rst_s), .IN_VALID(iv_s), .X(x_s), .Y(y_s),
    .C1X(c1x_s), .C1Y(c1y_s), .C2X(c2x_s), .C2Y(c2y_s),
    .COVER(cov_s), .DONE(done_s)
  );

  // ---------------- reference model ----------------
  function automatic bit inside_c(input int px, input int py, input int cx, input int cy, input int r2);
    return ((px-cx)*(px-cx) + (py-cy)*(py-cy)) <= r2;
  endfunction

  function automatic int scan_best(input int qx[$], input int qy[$], input int n, input int r2,
                                   input int fx, input int fy, output int bx, output int by);
    int best, s;
    best = 0; bx = 0; by = 0;
    for (int y = 0; y < n; y++)
      for (int x = 0; x < n; x++) begin
        s = 0;
        for (int i = 0; i < qx.size(); i++)
          if (inside_c(qx[i], qy[i], x, y, r2) || inside_c(qx[i], qy[i], fx, fy, r2)) s++;
        if (s > best) begin best = s; bx = x; by = y; end
      end
    return best;
  endfunction

  function automatic void model(input int qx[$], input int qy[$], input int cw, input int r2,
                                input int maxr, output int e1x, output int e1y, output int e2x,
                                output int e2y, output int ecov, output int erounds);
    int n, base, s2;
    n = 1 << cw;
    e1x = 0; e1y = 0; e2x = n-1; e2y = n-1; base = 0; erounds = 0; ecov = 0;
    while (1) begin
      void'(scan_best(qx, qy, n, r2, e2x, e2y, e1x, e1y));
      s2 = scan_best(qx, qy, n, r2, e1x, e1y, e2x, e2y);
      erounds++;
      if (s2 > base && erounds < maxr) base = s2;
      else begin ecov = s2; break; end
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic load_d(input int k, input int qx[$], input int qy[$], input bit gap);
    for (int i = 0; i < qx.size(); i++) begin
      @(negedge CLK); iv_d[k] = 1'b1; x_d[k] = 4'(qx[i]); y_d[k] = 4'(qy[i]);
      if (gap && i < qx.size()-1) begin
        @(negedge CLK); iv_d[k] = 1'b0; x_d[k] = 4'($urandom); y_d[k] = 4'($urandom);
      end
    end
    @(negedge CLK); iv_d[k] = 1'b0;
  endtask

  // n = cycle index of DONE, counting the first cycle after the last point as 1
  task automatic wait_d(input int k, output int n);
    n = 1;
    while (done_d[k] !== 1'b1 && n < 90000) begin @(negedge CLK); n++; end
  endtask

  task automatic load_s(input int qx[$], input int qy[$], input bit gap);
    for (int i = 0; i < qx.size(); i++) begin
      @(negedge CLK); iv_s = 1'b1; x_s = 2'(qx[i]); y_s = 2'(qy[i]);
      if (gap && i < qx.size()-1) begin
        @(negedge CLK); iv_s = 1'b0; x_s = 2'($urandom); y_s = 2'($urandom);
      end
    end
    @(negedge CLK); iv_s = 1'b0;
  endtask

  task automatic wait_s(output int n, input bit junk);
    n = 1;
    while (done_s !== 1'b1 && n < 20000) begin
      @(negedge CLK); n++;
      if (junk && done_s !== 1'b1) begin iv_s = 1'($urandom); x_s = 2'($urandom); y_s = 2'($urandom); end
    end
    iv_s = 1'b0;
  endtask

  function automatic void rand_pts(output int qx[$], output int qy[$]);
    qx = {}; qy = {};
    for (int i = 0; i < SN; i++) begin
      qx.push_back(int'($urandom_range(0, 3))); qy.push_back(int'($urandom_range(0, 3)));
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({c1x_d[k], c1y_d[k], c2x_d[k], c2y_d[k], cov_d[k], done_d[k]} !== 23'd0) begin
        errors++;
        $display("FAIL reset_def%0d: got %h expected 0", k, {c1x_d[k], c1y_d[k], c2x_d[k], c2y_d[k], cov_d[k], done_d[k]});
      end
    end
    checks++;
    if ({c1x_s, c1y_s, c2x_s, c2y_s, cov_s, done_s} !== 12'd0) begin
      errors++; $display("FAIL reset_small: got %h expected 0", {c1x_s, c1y_s, c2x_s, c2y_s, cov_s, done_s});
    end
  endtask

  task automatic test_two_rounds();
    int qx[$], qy[$], n;
    repeat (40) begin qx.push_back(3); qy.push_back(3); end
    load_d(0, qx, qy, 1'b0);
    wait_d(0, n);
    checks++;
    if (n !== DCYC) begin errors++; $display("FAIL two_rounds_cycles: got %0d expected %0d", n, DCYC); end
    checks++;
    if ({c1x_d[0], c1y_d[0], c2x_d[0], c2y_d[0], cov_d[0]} !== {4'd1, 4'd0, 4'd0, 4'd0, 6'd40}) begin
      errors++; $display("FAIL two_rounds_result: got %h expected %h",
                         {c1x_d[0], c1y_d[0], c2x_d[0], c2y_d[0], cov_d[0]}, {4'd1, 4'd0, 4'd0, 4'd0, 6'd40});
    end
    @(negedge CLK);
    checks++;
    if (done_d[0] !== 1'b0) begin errors++; $display("FAIL two_rounds_pulse: DONE got %b expected 0", done_d[0]); end
  endtask

  task automatic test_boundary_stall();
    int qx[$], qy[$], n;
    repeat (40) begin qx.push_back(4); qy.push_back(0); end
    load_d(1, qx, qy, 1'b1);
    wait_d(1, n);
    checks++;
    if (n !== DCYC) begin errors++; $display("FAIL boundary_cycles: got %0d expected %0d", n, DCYC); end
    checks++;
    if ({c1x_d[1], c1y_d[1], c2x_d[1], c2y_d[1], cov_d[1]} !== {4'd0, 4'd0, 4'd0, 4'd0, 6'd40}) begin
      errors++; $display("FAIL boundary_result: got %h expected %h",
                         {c1x_d[1], c1y_d[1], c2x_d[1], c2y_d[1], cov_d[1]}, {4'd0, 4'd0, 4'd0, 4'd0, 6'd40});
    end
  endtask

  task automatic test_rst_mid_scan();
    int qx[$], qy[$], n;
    bit early;
    repeat (20) begin qx.push_back(2); qy.push_back(2); end
    repeat (20) begin qx.push_back(13); qy.push_back(13); end
    load_d(2, qx, qy, 1'b0);
    early = 1'b0;
    repeat (300) begin @(negedge CLK); if (done_d[2] !== 1'b0) early = 1'b1; end
    checks++;
    if (early) begin errors++; $display("FAIL mid_scan_done: got early DONE expected none"); end
    rst_d[2] = 1'b1; iv_d[2] = 1'b1; x_d[2] = 4'd13; y_d[2] = 4'd13;
    repeat (2) @(negedge CLK);
    checks++;
    if ({c1x_d[2], c1y_d[2], c2x_d[2], c2y_d[2], cov_d[2], done_d[2]} !== 23'd0) begin
      errors++; $display("FAIL mid_scan_reset: got %h expected 0", {c1x_d[2], c1y_d[2], c2x_d[2], c2y_d[2], cov_d[2], done_d[2]});
    end
    rst_d[2] = 1'b0; iv_d[2] = 1'b0;
    load_d(2, qx, qy, 1'b0);
    wait_d(2, n);
    checks++;
    if (n !== DCYC) begin errors++; $display("FAIL reload_cycles: got %0d expected %0d", n, DCYC); end
    checks++;
    if ({c1x_d[2], c1y_d[2], c2x_d[2], c2y_d[2], cov_d[2]} !== {4'd0, 4'd0, 4'd13, 4'd9, 6'd40}) begin
      errors++; $display("FAIL reload_result: got %h expected %h",
                         {c1x_d[2], c1y_d[2], c2x_d[2], c2y_d[2], cov_d[2]}, {4'd0, 4'd0, 4'd13, 4'd9, 6'd40});
    end
    @(negedge CLK);
    checks++;
    if (done_d[2] !== 1'b0) begin errors++; $display("FAIL reload_pulse: DONE got %b expected 0", done_d[2]); end
  endtask

  // Back-to-back random frames; IN_VALID is toggled with junk while scanning.
  task automatic test_random_s();
    int qx[$], qy[$], n, e1x, e1y, e2x, e2y, ec, er;
    logic [10:0] exp_v, prev;
    prev = '0;
    for (int f = 0; f < 10; f++) begin
      rand_pts(qx, qy);
      model(qx, qy, SCW, SR2, SMR, e1x, e1y, e2x, e2y, ec, er);
      exp_v = {2'(e1x), 2'(e1y), 2'(e2x), 2'(e2y), 3'(ec)};
      load_s(qx, qy, 1'b0);
      if (f > 0) begin
        checks++;
        if ({c1x_s, c1y_s, c2x_s, c2y_s, cov_s} !== prev) begin
          errors++; $display("FAIL random_hold f%0d: got %h expected %h", f, {c1x_s, c1y_s, c2x_s, c2y_s, cov_s}, prev);
        end
      end
      wait_s(n, 1'b1);
      checks++;
      if (n !== er*(2*SSCAN+1)+1) begin
        errors++; $display("FAIL random_cycles f%0d: got %0d expected %0d", f, n, er*(2*SSCAN+1)+1);
      end
      checks++;
      if ({c1x_s, c1y_s, c2x_s, c2y_s, cov_s} !== exp_v) begin
        errors++; $display("FAIL random_result f%0d: got %h expected %h", f, {c1x_s, c1y_s, c2x_s, c2y_s, cov_s}, exp_v);
      end
      prev = exp_v;
    end
  endtask

  task automatic test_stall_s();
    int qx[$], qy[$], n, e1x, e1y, e2x, e2y, ec, er;
    logic [10:0] got1;
    rand_pts(qx, qy);
    model(qx, qy, SCW, SR2, SMR, e1x, e1y, e2x, e2y, ec, er);
    load_s(qx, qy, 1'b0);
    wait_s(n, 1'b0);
    got1 = {c1x_s, c1y_s, c2x_s, c2y_s, cov_s};
    @(negedge CLK);
    checks++;
    if (done_s !== 1'b0) begin errors++; $display("FAIL small_pulse: DONE got %b expected 0", done_s); end
    load_s(qx, qy, 1'b1);
    wait_s(n, 1'b0);
    checks++;
    if ({c1x_s, c1y_s, c2x_s, c2y_s, cov_s} !== got1) begin
      errors++; $display("FAIL stall_vs_contig: got %h expected %h", {c1x_s, c1y_s, c2x_s, c2y_s, cov_s}, got1);
    end
    checks++;
    if ({c1x_s, c1y_s, c2x_s, c2y_s, cov_s} !== {2'(e1x), 2'(e1y), 2'(e2x), 2'(e2y), 3'(ec)}) begin
      errors++; $display("FAIL stall_result: got %h expected %h", {c1x_s, c1y_s, c2x_s, c2y_s, cov_s},
                         {2'(e1x), 2'(e1y), 2'(e2x), 2'(e2y), 3'(ec)});
    end
  endtask

  task automatic test_rst_load_s();
    int qx[$], qy[$], px[$], py[$], n, e1x, e1y, e2x, e2y, ec, er;
    rand_pts(px, py);
    px = px[0:2]; py = py[0:2];
    load_s(px, py, 1'b0);
    rst_s = 1'b1; iv_s = 1'b1; x_s = 2'($urandom); y_s = 2'($urandom);
    repeat (2) @(negedge CLK);
    checks++;
    if ({c1x_s, c1y_s, c2x_s, c2y_s, cov_s, done_s} !== 12'd0) begin
      errors++; $display("FAIL rst_clears: got %h expected 0", {c1x_s, c1y_s, c2x_s, c2y_s, cov_s, done_s});
    end
    rst_s = 1'b0; iv_s = 1'b0;
    rand_pts(qx, qy);
    model(qx, qy, SCW, SR2, SMR, e1x, e1y, e2x, e2y, ec, er);
    load_s(qx, qy, 1'b0);
    wait_s(n, 1'b0);
    checks++;
    if (n !== er*(2*SSCAN+1)+1) begin
      errors++; $display("FAIL rst_load_cycles: got %0d expected %0d", n, er*(2*SSCAN+1)+1);
    end
    checks++;
    if ({c1x_s, c1y_s, c2x_s, c2y_s, cov_s} !== {2'(e1x), 2'(e1y), 2'(e2x), 2'(e2y), 3'(ec)}) begin
      errors++; $display("FAIL rst_load_result: got %h expected %h", {c1x_s, c1y_s, c2x_s, c2y_s, cov_s},
                         {2'(e1x), 2'(e1y), 2'(e2x), 2'(e2y), 3'(ec)});
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_d[k] = 1'b1; iv_d[k] = 1'b0; x_d[k] = '0; y_d[k] = '0;
    end
    rst_s = 1'b1; iv_s = 1'b0; x_s = '0; y_s = '0;
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 3; k++) rst_d[k] = 1'b0;
    rst_s = 1'b0;
    test_reset();
    // Default-size frames take ~41k cycles each, so the instances run side by side.
    fork
      test_two_rounds();
      test_boundary_stall();
      test_rst_mid_scan();
      begin
        test_random_s();
        test_stall_s();
        test_rst_load_s();
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/laser_search.md
LASER_SEARCH -- requirements
Module: laser_search

Interface
REQ-001 Parameter CW, default 4: coordinate width; grid is 2^CW x 2^CW.
REQ-002 Parameter NPTS, default 40: points per frame.
REQ-003 Parameter R2, default 16: squared radius; a point is covered when dx^2+dy^2 <= R2.
REQ-004 Parameter MAX_ROUNDS, default 4: refinement round limit, >=1.
REQ-005 CLK  in  1  clock; all logic rising-edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 IN_VALID  in  1  qualifies X/Y during loading.
REQ-008 X, Y  in  CW each  point coordinate.
REQ-009 C1X, C1Y, C2X, C2Y  out  CW each  circle centres, registered.
REQ-010 COVER  out  clog2(NPTS+1)  union count of points covered by either circle, registered.
REQ-011 DONE  out  1  result-valid pulse.

Function
REQ-012 The block SHALL use states IDLE, LOAD, SCAN1, SCAN2, CHECK, FINISH.
REQ-013 In IDLE, the first IN_VALID=1 SHALL store point 0 and move to LOAD.
REQ-014 In LOAD, each IN_VALID=1 cycle SHALL store the next point; IN_VALID=0 cycles SHALL stall without storing; after point NPTS-1 the block SHALL enter SCAN1.
REQ-015 IN_VALID SHALL be ignored in SCAN1, SCAN2, CHECK and FINISH.
REQ-016 At each frame start, working centres SHALL be C1=(0,0) and C2=(2^CW-1,2^CW-1), with round base count 0.
REQ-017 SCAN1 SHALL visit every candidate in raster order (y outer, x inner, 0 to 2^CW-1) and evaluate NPTS points one per cycle: NPTS*2^(2*CW) cycles per scan.
REQ-018 Candidate score SHALL be the count of points inside the candidate OR inside the fixed other circle (C2 during SCAN1).
REQ-019 Best score SHALL start at 0 per scan; a candidate SHALL replace the best only if strictly greater, so ties keep the earliest raster candidate.
REQ-020 At SCAN1 end, working C1 SHALL take the best candidate; SCAN2 SHALL then repeat the procedure for C2 with C1 fixed.
REQ-021 CHECK (1 cycle) SHALL compare the SCAN2 best score with the round base: if greater and rounds done < MAX_ROUNDS, base := score and go to SCAN1; otherwise go to FINISH.
REQ-022 Differences SHALL be signed CW+1 bits; squares and sum SHALL be wide enough (2*CW+3 bits) that no overflow occurs; comparison with R2 is inclusive.
REQ-023 FINISH (1 cycle) SHALL load C1X/C1Y/C2X/C2Y/COVER from working values, assert DONE for exactly that cycle, then return to IDLE.
REQ-024 Outputs SHALL hold their values until the next FINISH or reset.
REQ-025 A new frame MAY start in IDLE on the cycle after DONE.

Reset
REQ-026 RST=1 SHALL force IDLE, clear point index, round count, scores, DONE=0, COVER=0, C1X=C1Y=C2X=C2Y=0.
REQ-027 RST in any state, including mid-LOAD or mid-SCAN, SHALL discard the partial frame; RST dominates IN_VALID in the same cycle.
REQ-028 Point storage SHALL NOT require reset.

Structure
REQ-029 Package laser_pkg SHALL hold the state enum and default values for CW, NPTS, R2, MAX_ROUNDS.
REQ-030 Sub-module laser_incircle (combinational: point, centre, R2 -> covered) SHALL be instantiated twice: candidate and fixed circle.
REQ-031 Point storage SHALL be a register array of NPTS x 2*CW bits, read one entry per cycle.

Verification (defaults)
REQ-032 Load 40 x (3,3) -> DONE after 2 rounds; C1=(1,0), C2=(0,0), COVER=40.
REQ-033 Load 20 x (2,2) then 20 x (13,13) -> C1=(0,0), C2=(13,9), COVER=40.
REQ-034 Load 40 x (4,0) (boundary, d^2=16) -> C1=(0,0), C2=(0,0), COVER=40.
REQ-035 Load with IN_VALID=0 on every other cycle -> results identical to the contiguous load of the same points.
REQ-036 RST during SCAN1, then reload scenario REQ-033 -> DONE low until the new result; outputs as in REQ-033.
REQ-037 Scenario REQ-033 -> DONE high exactly one cycle; total cycles from last point to DONE = 4*10240 + 2 CHECK + 1, +/- fixed FSM overhead, constant across runs.
